hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_WIDTH, default 5, register-index width.
REQ-002 Parameter FWD_EN, default 1, 1 = forwarding mode, 0 = stall-only mode.
REQ-003 Parameter PERF_WIDTH, default 32, stall-counter width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 Rs1D, Rs2D  input  REG_WIDTH  decode-stage source indices.
REQ-007 Rs1E, Rs2E, RdE  input  REG_WIDTH  execute-stage source and destination indices.
REQ-008 RdM, RdW  input  REG_WIDTH  memory- and writeback-stage destination indices.
REQ-009 regwriteE, regwriteM, regwriteW  input  1  stage writes the register file.
REQ-010 loadE  input  1  execute-stage instruction is a load.
REQ-011 PCSrcE  input  1  taken branch or jump resolved in execute.
REQ-012 mdu_busyE  input  1  multi-cycle multiply/divide unit in execute is not done.
REQ-013 stallF, stallD, stallE  output  1  hold the fetch, decode or execute register.
REQ-014 flushD, flushE  output  1  bubble the decode or execute register.
REQ-015 forwardAE, forwardBE  output  fwd_sel_e  ALU operand source select.
REQ-016 stall_cnt  output  PERF_WIDTH  count of cycles with stallD asserted.

Function
REQ-017 A source index matches a stage only when it equals that stage's Rd, that stage's regwrite is 1, and the Rd is nonzero; x0 never matches.
REQ-018 Forward select: FWD_MEM on a memory-stage match, else FWD_WB on a writeback-stage match, else FWD_NONE; memory stage has priority; outputs are combinational, no latency.
REQ-019 When FWD_EN=1, a load-use hazard is loadE & (Rs1D or Rs2D matches RdE); it asserts stallF, stallD and flushE in the same cycle, for exactly one cycle.
REQ-020 When FWD_EN=0, forwardAE and forwardBE are constantly FWD_NONE.
REQ-021 When FWD_EN=0, a decode-stage source that matches RdE gives 2 stall cycles; otherwise a match on RdM gives 1 stall cycle; a match on RdW gives 0 (the register file is write-first).
REQ-022 Each stall cycle asserts stallF, stallD and flushE.
REQ-023 Stall FSM states: IDLE and HOLD, with a 2-bit remaining-cycle counter cnt.
REQ-024 In IDLE on a hazard: stall outputs assert combinationally in that cycle; cnt loads (required cycles - 1); the FSM goes to HOLD if that value is nonzero.
REQ-025 In HOLD: stall outputs stay asserted; hazard detection is ignored; cnt decrements each cycle; the FSM returns to IDLE when cnt reaches 0.
REQ-026 mdu_busyE has highest priority: it asserts stallF, stallD and stallE, with flushE=0 and flushD=0; PCSrcE is ignored; the FSM and cnt freeze.
REQ-027 PCSrcE without mdu_busyE asserts flushD and flushE combinationally in the same cycle and deasserts stallF and stallD.
REQ-028 PCSrcE without mdu_busyE also forces the FSM to IDLE with cnt=0 at the next edge, abandoning any pending stall.
REQ-029 stallE is asserted only under mdu_busyE.
REQ-030 stall_cnt increments on every edge where stallD=1 and saturates at all-ones; it never wraps.

Reset
REQ-031 While rst=1: FSM=IDLE, cnt=0, stall_cnt=0.
REQ-032 While rst=1: all stall and flush outputs are 0 and forward selects are FWD_NONE, irrespective of inputs.
REQ-033 Reset asserted in HOLD drops the stall outputs immediately, without waiting for a clock edge.

Structure
REQ-034 fwd_sel_e (2-bit enum: FWD_NONE=00, FWD_WB=01, FWD_MEM=10) is defined in rv32i_pkg.
REQ-035 The stall-cycle constants STALL_E=2 and STALL_M=1 are defined in rv32i_pkg.
REQ-036 Forward-select logic is one sub-module, hazard_fwd_sel, instantiated once per operand (A and B).
REQ-037 The FSM, priority logic and performance counter stay in the top module.

Verification
REQ-038 FWD_EN=1, RdM=5, regwriteM=1, Rs1E=5 -> forwardAE=FWD_MEM; with additionally RdW=5, regwriteW=1 -> still FWD_MEM; with RdM=0 instead -> FWD_WB.
REQ-039 FWD_EN=1, loadE=1, regwriteE=1, RdE=7, Rs2D=7 -> stallF=stallD=flushE=1 for 1 cycle, then 0; stall_cnt=1.
REQ-040 FWD_EN=0, regwriteE=1, RdE=3, Rs1D=3 -> stall for exactly 2 cycles; with RdM=3 instead -> 1 cycle; with Rs1D=RdE=0 -> no stall.
REQ-041 FWD_EN=0: PCSrcE=1 in the second stall cycle of REQ-040 -> flushD=flushE=1 and stallF=stallD=0 that cycle, FSM in IDLE at the next cycle.
REQ-042 mdu_busyE=1 for 4 cycles while PCSrcE=1 -> stallF=stallD=stallE=1, flushD=flushE=0 for all 4 cycles; stall_cnt advances by 4.
REQ-043 Preload stall_cnt to all-ones, then stall -> stall_cnt holds all-ones; assert rst mid-HOLD -> outputs 0 immediately, stall_cnt=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I pipeline hazard logic.
package rv32i_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hz_state_e;

  // Stall cycles needed in stall-only mode when the producer sits in E or M
  localparam int unsigned STALL_E = 2;
  localparam int unsigned STALL_M = 1;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: the memory stage wins over writeback, and x0 never forwards.
module hazard_fwd_sel
  import rv32i_pkg::*;
#(
  parameter int REG_WIDTH = 5,
  parameter int FWD_EN    = 1
) (
  input  logic [REG_WIDTH-1:0] rs_i,
  input  logic [REG_WIDTH-1:0] rdM_i,
  input  logic                 regwriteM_i,
  input  logic [REG_WIDTH-1:0] rdW_i,
  input  logic                 regwriteW_i,
  output fwd_sel_e             sel_o
);

  logic hit_m, hit_w;

  assign hit_m = regwriteM_i && (rdM_i != '0) && (rs_i == rdM_i);
  assign hit_w = regwriteW_i && (rdW_i != '0) && (rs_i == rdW_i);

  always_comb begin
    sel_o = FWD_NONE;
    if (FWD_EN != 0) begin
      if (hit_m)      sel_o = FWD_MEM;
      else if (hit_w) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: operand forwarding, load-use / RAW stalls,
// branch flushes, MDU back-pressure and a saturating stall counter.
module hazard_ctrl_unit
  import rv32i_pkg::*;
#(
  parameter int REG_WIDTH  = 5,
  parameter int FWD_EN     = 1,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  Rs1D,
  input  logic [REG_WIDTH-1:0]  Rs2D,
  input  logic [REG_WIDTH-1:0]  Rs1E,
  input  logic [REG_WIDTH-1:0]  Rs2E,
  input  logic [REG_WIDTH-1:0]  RdE,
  input  logic [REG_WIDTH-1:0]  RdM,
  input  logic [REG_WIDTH-1:0]  RdW,
  input  logic                  regwriteE,
  input  logic                  regwriteM,
  input  logic                  regwriteW,
  input  logic                  loadE,
  input  logic                  PCSrcE,
  input  logic                  mdu_busyE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  flushD,
  output logic                  flushE,
  output fwd_sel_e              forwardAE,
  output fwd_sel_e              forwardBE,
  output logic [PERF_WIDTH-1:0] stall_cnt
);

  function automatic logic hit(input logic [REG_WIDTH-1:0] src,
                               input logic [REG_WIDTH-1:0] rd,
                               input logic                 we);
    return we && (rd != '0) && (src == rd);
  endfunction

  fwd_sel_e fwd_a, fwd_b;

  hazard_fwd_sel #(.REG_WIDTH(REG_WIDTH), .FWD_EN(FWD_EN)) u_fwd_a (
    .rs_i(Rs1E), .rdM_i(RdM), .regwriteM_i(regwriteM),
    .rdW_i(RdW), .regwriteW_i(regwriteW), .sel_o(fwd_a)
  );

  hazard_fwd_sel #(.REG_WIDTH(REG_WIDTH), .FWD_EN(FWD_EN)) u_fwd_b (
    .rs_i(Rs2E), .rdM_i(RdM), .regwriteM_i(regwriteM),
    .rdW_i(RdW), .regwriteW_i(regwriteW), .sel_o(fwd_b)
  );

  assign forwardAE = rst ? FWD_NONE : fwd_a;
  assign forwardBE = rst ? FWD_NONE : fwd_b;

  logic       hit_e, hit_m;
  logic [1:0] need;

  assign hit_e = hit(Rs1D, RdE, regwriteE) | hit(Rs2D, RdE, regwriteE);
  assign hit_m = hit(Rs1D, RdM, regwriteM) | hit(Rs2D, RdM, regwriteM);

  // A writeback-stage match never stalls: the register file is write-first.
  always_comb begin
    need = 2'd0;
    if (FWD_EN != 0) begin
      if (loadE && hit_e) need = 2'd1;
    end else if (hit_e) begin
      need = 2'(STALL_E);
    end else if (hit_m) begin
      need = 2'(STALL_M);
    end
  end

  hz_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       stall_c, stallE_c, flushD_c, flushE_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    stallE_c = 1'b0;
    flushD_c = 1'b0;
    flushE_c = 1'b0;
    if (mdu_busyE) begin
      stall_c  = 1'b1;
      stallE_c = 1'b1;
    end else if (PCSrcE) begin
      flushD_c = 1'b1;
      flushE_c = 1'b1;
      state_d  = ST_IDLE;
      cnt_d    = 2'd0;
    end else if (state_q == ST_HOLD) begin
      stall_c  = 1'b1;
      flushE_c = 1'b1;
      if (cnt_q <= 2'd1) begin
        cnt_d   = 2'd0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (need != 2'd0) begin
      stall_c  = 1'b1;
      flushE_c = 1'b1;
      cnt_d    = need - 2'd1;
      if (cnt_d != 2'd0) state_d = ST_HOLD;
    end
  end

  assign stallF = stall_c  & ~rst;
  assign stallD = stall_c  & ~rst;
  assign stallE = stallE_c & ~rst;
  assign flushD = flushD_c & ~rst;
  assign flushE = flushE_c & ~rst;

  logic [PERF_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stallD && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: one forwarding-mode instance and one stall-only instance with a narrow counter.
module tb_hazard_ctrl_unit;
  import rv32i_pkg::*;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww, lde, pcs, mdu;
  } hin_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hin_t i1, i0;
  logic [4:0] c1, c0;  // {stallF, stallD, stallE, flushD, flushE}
  fwd_sel_e fa1, fb1, fa0, fb0;
  logic [31:0] sc1;
  logic [2:0]  sc0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_WIDTH(5), .FWD_EN(1), .PERF_WIDTH(32)) u_fwd (
    .clk(clk), .rst(rst),
    .Rs1D(i1.rs1d), .Rs2D(i1.rs2d), .Rs1E(i1.rs1e), .Rs2E(i1.rs2e),
    .RdE(i1.rde), .RdM(i1.rdm), .RdW(i1.rdw),
    .regwriteE(i1.rwe), .regwriteM(i1.rwm), .regwriteW(i1.rww),
    .loadE(i1.lde), .PCSrcE(i1.pcs), .mdu_busyE(i1.mdu),
    .stallF(c1[4]), .stallD(c1[3]), .stallE(c1[2]), .flushD(c1[1]), .flushE(c1[0]),
    .forwardAE(fa1), .forwardBE(fb1), .stall_cnt(sc1)
  );

  hazard_ctrl_unit #(.REG_WIDTH(5), .FWD_EN(0), .PERF_WIDTH(3)) u_stl (
    .clk(clk), .rst(rst),
    .Rs1D(i0.rs1d), .Rs2D(i0.rs2d), .Rs1E(i0.rs1e), .Rs2E(i0.rs2e),
    .RdE(i0.rde), .RdM(i0.rdm), .RdW(i0.rdw),
    .regwriteE(i0.rwe), .regwriteM(i0.rwm), .regwriteW(i0.rww),
    .loadE(i0.lde), .PCSrcE(i0.pcs), .mdu_busyE(i0.mdu),
    .stallF(c0[4]), .stallD(c0[3]), .stallE(c0[2]), .flushD(c0[1]), .flushE(c0[0]),
    .forwardAE(fa0), .forwardBE(fb0), .stall_cnt(sc0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] STL = 5'b11001;  // stallF, stallD, flushE
  localparam logic [4:0] MDU = 5'b11100;
  localparam logic [4:0] BRF = 5'b00011;

  initial begin
    i1 = '0; i0 = '0;
    i1.rs1e = 5'd5; i1.rdm = 5'd5; i1.rwm = 1'b1;
    i1.lde = 1'b1; i1.rwe = 1'b1; i1.rde = 5'd7; i1.rs2d = 5'd7;
    i0.rs1d = 5'd3; i0.rde = 5'd3; i0.rwe = 1'b1; i0.pcs = 1'b0; i0.mdu = 1'b1;
    tick(); tick();
    chk("rst_ctl1", 32'(c1), 32'd0);
    chk("rst_ctl0", 32'(c0), 32'd0);
    chk("rst_fwdA", 32'(fa1), 32'(FWD_NONE));
    chk("rst_cnt1", sc1, 32'd0);
    chk("rst_cnt0", 32'(sc0), 32'd0);
    i1 = '0; i0 = '0;
    rst = 1'b0;
    tick();

    // forwarding priority
    i1.rs1e = 5'd5; i1.rdm = 5'd5; i1.rwm = 1'b1; #1;
    chk("fwdA_mem", 32'(fa1), 32'(FWD_MEM));
    chk("fwdB_none", 32'(fb1), 32'(FWD_NONE));
    i1.rdw = 5'd5; i1.rww = 1'b1; #1;
    chk("fwdA_mem_prio", 32'(fa1), 32'(FWD_MEM));
    i1.rdm = 5'd0; #1;
    chk("fwdA_wb", 32'(fa1), 32'(FWD_WB));
    i1.rs2e = 5'd5; #1;
    chk("fwdB_wb", 32'(fb1), 32'(FWD_WB));
    i1.rs1e = 5'd0; i1.rdw = 5'd0; #1;
    chk("fwdA_x0", 32'(fa1), 32'(FWD_NONE));
    chk("fwd_nostall", 32'(c1), 32'd0);

    // load-use
    i1 = '0; i1.rwe = 1'b1; i1.rde = 5'd7; i1.rs2d = 5'd7; #1;
    chk("nonload_nostall", 32'(c1), 32'd0);
    i1.lde = 1'b1; #1;
    chk("loaduse", 32'(c1), 32'(STL));
    tick();
    i1 = '0; i1.rdm = 5'd7; i1.rwm = 1'b1; i1.rs2d = 5'd7; #1;
    chk("loaduse_end", 32'(c1), 32'd0);
    chk("cnt_loaduse", sc1, 32'd1);

    // MDU busy overrides a taken branch
    i1 = '0; i1.mdu = 1'b1; i1.pcs = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("mdu_%0d", k), 32'(c1), 32'(MDU));
      tick();
    end
    i1.mdu = 1'b0; #1;
    chk("cnt_mdu", sc1, 32'd5);
    chk("br_flush", 32'(c1), 32'(BRF));
    tick();
    i1 = '0;

    // stall-only mode
    i0.rs1e = 5'd5; i0.rdm = 5'd5; i0.rwm = 1'b1; #1;
    chk("fwd_off", 32'(fa0), 32'(FWD_NONE));
    i0 = '0; i0.rs1d = 5'd3; i0.rde = 5'd3; i0.rwe = 1'b1; #1;
    chk("stE_c1", 32'(c0), 32'(STL));
    tick();
    i0 = '0; #1;
    chk("stE_c2", 32'(c0), 32'(STL));
    tick();
    chk("stE_end", 32'(c0), 32'd0);
    chk("cnt_stE", 32'(sc0), 32'd2);
    i0.rs1d = 5'd3; i0.rdm = 5'd3; i0.rwm = 1'b1; #1;
    chk("stM_c1", 32'(c0), 32'(STL));
    tick();
    i0 = '0; #1;
    chk("stM_end", 32'(c0), 32'd0);
    chk("cnt_stM", 32'(sc0), 32'd3);
    i0.rwe = 1'b1; #1;
    chk("x0_nostall", 32'(c0), 32'd0);
    i0 = '0; i0.rs2d = 5'd4; i0.rdw = 5'd4; i0.rww = 1'b1; #1;
    chk("wb_nostall", 32'(c0), 32'd0);

    // branch in the second stall cycle
    i0 = '0; i0.rs1d = 5'd3; i0.rde = 5'd3; i0.rwe = 1'b1; #1;
    chk("brh_c1", 32'(c0), 32'(STL));
    tick();
    i0 = '0; i0.pcs = 1'b1; #1;
    chk("br_in_hold", 32'(c0), 32'(BRF));
    tick();
    i0 = '0; #1;
    chk("idle_after_br", 32'(c0), 32'd0);
    chk("cnt_br", 32'(sc0), 32'd4);

    // branch on the hazard cycle must keep the FSM out of HOLD
    i0.rs1d = 5'd3; i0.rde = 5'd3; i0.rwe = 1'b1; i0.pcs = 1'b1; #1;
    chk("br_over_hz", 32'(c0), 32'(BRF));
    tick();
    i0 = '0; #1;
    chk("no_hold", 32'(c0), 32'd0);
    chk("cnt_no_hold", 32'(sc0), 32'd4);

    // counter saturation
    i0.mdu = 1'b1;
    repeat (5) tick();
    i0.mdu = 1'b0; #1;
    chk("cnt_sat", 32'(sc0), 32'd7);

    // async reset while holding
    i0.rs1d = 5'd3; i0.rde = 5'd3; i0.rwe = 1'b1; #1;
    tick();
    i0 = '0; #1;
    chk("hold", 32'(c0), 32'(STL));
    chk("cnt_sat_hold", 32'(sc0), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctl", 32'(c0), 32'd0);
    chk("rst_async_cnt", 32'(sc0), 32'd0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("idle_after_rst", 32'(c0), 32'd0);
    tick();
    chk("idle_after_rst2", 32'(c0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
